// File: rtl/vga_fml_defs.sv
// Shared FML arbitration definitions: bus-cycle state encoding and burst geometry,
// common to the VGA arbiter and the fmlbrg-side logic.
package vga_fml_defs;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_BURST = 2'd2
  } fml_state_t;

  localparam int unsigned BURST_LEN = 4;
  localparam int unsigned BEAT_W    = 2;

  localparam logic OWNER_LCD = 1'b0;
  localparam logic OWNER_CPU = 1'b1;

  function automatic logic last_beat(input logic [BEAT_W-1:0] beat);
    return beat == BEAT_W'(BURST_LEN - 1);
  endfunction

endpackage

// File: rtl/vga_fml_arbiter.sv
// Two-master (LCD refresh, CPU) arbiter in front of a single FML slave port.
// One grant per bus cycle: arbitrate in IDLE, strobe in REQ, then a fixed 4-beat burst.
module vga_fml_arbiter
  import vga_fml_defs::*;
#(
  parameter int fml_depth   = 20,
  parameter int lcd_max_run = 4
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,

  input  logic [fml_depth-1:0] lcd_fml_adr,
  input  logic                 lcd_fml_stb,
  input  logic                 lcd_fml_we,
  input  logic [1:0]           lcd_fml_sel,
  input  logic [15:0]          lcd_fml_do,
  output logic                 lcd_fml_ack,
  output logic [15:0]          lcd_fml_di,

  input  logic [fml_depth-1:0] cpu_fml_adr,
  input  logic                 cpu_fml_stb,
  input  logic                 cpu_fml_we,
  input  logic [1:0]           cpu_fml_sel,
  input  logic [15:0]          cpu_fml_do,
  output logic                 cpu_fml_ack,
  output logic [15:0]          cpu_fml_di,

  output logic [fml_depth-1:0] fml_adr,
  output logic                 fml_stb,
  output logic                 fml_we,
  output logic [1:0]           fml_sel,
  output logic [15:0]          fml_do,
  input  logic                 fml_ack,
  input  logic [15:0]          fml_di,

  output logic                 owner
);

  fml_state_t        state;
  logic [3:0]        lcd_run;
  logic [BEAT_W-1:0] beat;

  logic lcd_max_hit;
  logic cpu_wins;
  logic owner_stb;
  logic in_req;

  // The CPU only beats a pending LCD request once LCD has used up its run allowance.
  assign lcd_max_hit = (lcd_run == 4'(lcd_max_run));
  assign cpu_wins    = cpu_fml_stb & (~lcd_fml_stb | lcd_max_hit);
  assign owner_stb   = (owner == OWNER_CPU) ? cpu_fml_stb : lcd_fml_stb;
  assign in_req      = (state == ST_REQ) & ~sys_rst;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state   <= ST_IDLE;
      owner   <= OWNER_LCD;
      lcd_run <= '0;
      beat    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (lcd_fml_stb | cpu_fml_stb) begin
            owner <= cpu_wins;
            state <= ST_REQ;
            if (!cpu_wins && cpu_fml_stb)
              lcd_run <= lcd_run + 4'd1;
            else
              lcd_run <= '0;
          end
        end
        ST_REQ: begin
          if (fml_ack) begin
            state <= ST_BURST;
            beat  <= '0;
          end else if (!owner_stb) begin
            // Master withdrew before the slave accepted: abandon the grant.
            state <= ST_IDLE;
          end
        end
        ST_BURST: begin
          if (last_beat(beat))
            state <= ST_IDLE;
          else
            beat <= beat + 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign fml_stb = in_req & owner_stb;
  assign fml_adr = (owner == OWNER_CPU) ? cpu_fml_adr : lcd_fml_adr;
  assign fml_we  = (owner == OWNER_CPU) ? cpu_fml_we  : lcd_fml_we;
  assign fml_sel = (owner == OWNER_CPU) ? cpu_fml_sel : lcd_fml_sel;

  always_comb begin
    fml_do = '0;
    if (state != ST_IDLE)
      fml_do = (owner == OWNER_CPU) ? cpu_fml_do : lcd_fml_do;
  end

  // Acks are only meaningful while a strobe is outstanding.
  assign lcd_fml_ack = in_req & fml_ack & (owner == OWNER_LCD);
  assign cpu_fml_ack = in_req & fml_ack & (owner == OWNER_CPU);

  assign lcd_fml_di = fml_di;
  assign cpu_fml_di = fml_di;

endmodule

// File: doc/vga_fml_arbiter.md
VGA_FML_ARBITER -- requirements
Module: vga_fml_arbiter

Interface
REQ-001 Parameter fml_depth, default 20: FML address width (1 MB video memory).
REQ-002 Parameter lcd_max_run, default 4: maximum consecutive LCD grants while CPU waits; legal range 1..15.
REQ-003 sys_clk  in  1  single clock; every register is clocked on the rising edge.
REQ-004 sys_rst  in  1  synchronous, active-high reset.
REQ-005 lcd_fml_adr/stb/we/sel/do  in  fml_depth/1/1/2/16  LCD master request; lcd_fml_ack out 1; lcd_fml_di out 16.
REQ-006 cpu_fml_adr/stb/we/sel/do  in  fml_depth/1/1/2/16  CPU master request; cpu_fml_ack out 1; cpu_fml_di out 16.
REQ-007 fml_adr/stb/we/sel/do  out  fml_depth/1/1/2/16  shared FML slave port to SDRAM controller; fml_ack in 1; fml_di in 16.
REQ-008 owner  out  1  current/last grant, 0 = LCD, 1 = CPU (debug, registered).

Function
REQ-009 FSM states: IDLE, REQ (slave strobed, awaiting ack), BURST (4-beat data phase).
REQ-010 IDLE: any master stb high -> latch owner, go REQ next cycle; no stb -> stay IDLE; fml_stb low in IDLE.
REQ-011 Arbitration: LCD wins when both request, unless lcd_run == lcd_max_run and cpu stb high, then CPU wins.
REQ-012 lcd_run (4 bit): +1 on LCD grant while cpu stb high; cleared on CPU grant or on LCD grant with cpu stb low; never exceeds lcd_max_run.
REQ-013 REQ: fml_stb = owner's stb; fml_adr/we/sel = owner's signals, combinational mux on registered owner.
REQ-014 REQ: fml_ack high -> go BURST, beat counter loaded 0; owner's ack = fml_ack, other master's ack = 0 in all states.
REQ-015 REQ: owner drops stb before ack (protocol error) -> return IDLE next cycle, no ack forwarded.
REQ-016 BURST: lasts exactly 4 cycles (counter 0..3), fml_stb low, then IDLE; total occupancy per grant = 1 arbitration + N wait + 1 ack + 4 burst cycles.
REQ-017 Write data: fml_do = owner's do in REQ and BURST (beats at ack cycle and 3 following); fml_do = 0 in IDLE.
REQ-018 Read data: fml_di is broadcast unmodified to lcd_fml_di and cpu_fml_di every cycle; masters sample in their own window.
REQ-019 New arbitration only from IDLE; a request arriving during BURST waits, minimum back-to-back grant spacing = 6 cycles.
REQ-020 fml_ack outside REQ is ignored (not forwarded, no state change).
REQ-021 Latency: stb rising at cycle 0 with bus IDLE -> fml_stb high at cycle 1.

Reset
REQ-022 On sys_rst: state = IDLE, owner = 0, lcd_run = 0, beat counter = 0; fml_stb, lcd_fml_ack, cpu_fml_ack = 0 in the same cycle reset is sampled.
REQ-023 Reset asserted mid-REQ or mid-BURST aborts the transaction; no ack is forwarded after the reset edge.

Structure
REQ-024 State encodings and burst length constant (4) live in shared header vga_fml_defs, reused by fmlbrg-side logic.
REQ-025 Single flat module; no sub-module; purely registered FSM plus combinational muxes, no combinational path from fml_ack to fml_stb.

Verification
REQ-026 LCD only, adr 0x01230, ack after 2 wait cycles -> fml_stb high cycles 1-3, lcd_fml_ack at cycle 3, IDLE at cycle 8, cpu_fml_ack never high.
REQ-027 Both request continuously, lcd_max_run=4 -> grant sequence LCD,LCD,LCD,LCD,CPU,LCD,... repeating.
REQ-028 CPU write 0xAAAA,0x5555,0x1234,0xBEEF on beats -> fml_do shows those 4 values on ack cycle and next 3 cycles, fml_we=1.
REQ-029 CPU stb dropped in REQ before ack -> IDLE next cycle, no cpu_fml_ack, then pending LCD granted.
REQ-030 sys_rst at BURST beat 1 -> next cycle IDLE, fml_stb=0, owner=0, lcd_run=0; stray fml_ack afterwards ignored.
REQ-031 LCD request arrives during CPU BURST beat 2 -> fml_stb for LCD first high 2 cycles after burst ends (IDLE then REQ).
